run_detector: RTL and testbench

RUN_DETECTOR -- requirements
Module: run_detector

---
 rtl/run_det_pkg.sv | 14 +
 rtl/run_detector_if.sv | 26 ++
 rtl/sat_counter.sv | 22 ++
 rtl/run_detector.sv | 83 ++++++++
 tb/tb_run_detector.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/run_det_pkg.sv
// Shared types and width helpers for the run detector.
package run_det_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Bits needed to hold the values 0..max_val.
  function automatic int unsigned width_for(input int unsigned max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/run_detector_if.sv
// Serial-bit and result signals of the run detector.
interface run_detector_if #(
  parameter int unsigned LEN_W = 3,
  parameter int unsigned CNT_W = 8
);

  logic             w;
  logic             en;
  logic             mode;
  logic             clr;
  logic             z;
  logic             z_bit;
  logic [LEN_W-1:0] run_len;
  logic [CNT_W-1:0] match_count;

  modport master (
    output w, en, mode, clr,
    input  z, z_bit, run_len, match_count
  );

  modport slave (
    input  w, en, mode, clr,
    output z, z_bit, run_len, match_count
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear that overrides increment.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/run_detector.sv
// Detects runs of RUN_LEN equal serial bits, with overlap/non-overlap
// restart and a saturating match counter.
module run_detector
  import run_det_pkg::*;
#(
  parameter int unsigned RUN_LEN = 4,
  parameter int unsigned CNT_W   = 8
) (
  input logic          Clk,
  input logic          Resetn,
  run_detector_if.slave bus
);

  localparam int unsigned LEN_W = width_for(RUN_LEN);
  localparam logic [LEN_W-1:0] FULL = LEN_W'(RUN_LEN);
  localparam logic [LEN_W-1:0] ONE  = LEN_W'(1);

  state_e           state_q, state_d;
  logic             bit_q, bit_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             match_inc;
  logic [CNT_W-1:0] count;

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= IDLE;
      bit_q   <= 1'b0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      len_q   <= len_d;
    end
  end

  // Next run state; a full run either holds (overlap) or restarts at 1.
  always_comb begin
    state_d   = state_q;
    bit_d     = bit_q;
    len_d     = len_q;
    match_inc = 1'b0;
    if (bus.en) begin
      case (state_q)
        IDLE: begin
          state_d = RUN;
          bit_d   = bus.w;
          len_d   = ONE;
        end
        RUN: begin
          if (bus.w != bit_q) begin
            bit_d = bus.w;
            len_d = ONE;
          end else if (len_q != FULL) begin
            len_d = len_q + ONE;
          end else if (!bus.mode) begin
            len_d = ONE;
          end
        end
        default: begin
          state_d = IDLE;
          len_d   = '0;
        end
      endcase
      match_inc = (len_d == FULL) && (len_q != FULL);
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_match_cnt (
    .clk   (Clk),
    .rst_n (Resetn),
    .inc   (match_inc),
    .clr   (bus.clr),
    .count (count)
  );

  assign bus.z           = (state_q == RUN) && (len_q == FULL);
  assign bus.z_bit       = bit_q;
  assign bus.run_len     = len_q;
  assign bus.match_count = count;

endmodule

// File: tb/tb_run_detector.sv
// Self-checking bench for run_detector: vector table, corner sequences and
// randomized segments against a history-based reference model.
module tb_run_detector;
  import run_det_pkg::*;

  localparam int unsigned R  = 4;
  localparam int unsigned LW = width_for(R);

  logic Clk = 1'b0;
  logic Resetn = 1'b0;
  always #5 Clk = ~Clk;

  run_detector_if #(.LEN_W(LW), .CNT_W(8)) bus8 ();
  run_detector_if #(.LEN_W(LW), .CNT_W(2)) bus2 ();

  assign bus2.w    = bus8.w;
  assign bus2.en   = bus8.en;
  assign bus2.mode = bus8.mode;
  assign bus2.clr  = bus8.clr;

  run_detector #(.RUN_LEN(R), .CNT_W(8)) u_dut (.Clk(Clk), .Resetn(Resetn), .bus(bus8.slave));
  run_detector #(.RUN_LEN(R), .CNT_W(2)) u_sat (.Clk(Clk), .Resetn(Resetn), .bus(bus2.slave));

  int total = 0;
  int bad   = 0;

  // Model: length of the trailing equal-bit streak since reset, plus match total since clr.
  int m_streak;
  bit m_any;
  bit m_last;
  int m_cnt;
  bit m_mode;

  typedef struct {
    logic          w;
    logic [LW-1:0] len;
    logic          z;
    logic          zb;
    logic [7:0]    cnt;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_len();
    if (!m_any) return 0;
    if (m_mode) return (m_streak < int'(R)) ? m_streak : int'(R);
    return ((m_streak - 1) % int'(R)) + 1;
  endfunction

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic model_reset();
    m_streak = 0;
    m_any    = 1'b0;
    m_last   = 1'b0;
    m_cnt    = 0;
  endtask

  task automatic model_update(input bit w, input bit en, input bit mode, input bit clr);
    bit hit;
    hit = 1'b0;
    if (en) begin
      m_streak = (m_any && (w == m_last)) ? m_streak + 1 : 1;
      m_last   = w;
      m_any    = 1'b1;
      hit = mode ? (m_streak == int'(R)) : ((m_streak % int'(R)) == 0);
    end
    if (clr) m_cnt = 0;
    else if (hit) m_cnt++;
  endtask

  task automatic check_model();
    int l;
    l = exp_len();
    chk("z",       int'(bus8.z),           int'(l == int'(R)));
    chk("z_bit",   int'(bus8.z_bit),       int'(m_last));
    chk("run_len", int'(bus8.run_len),     l);
    chk("count8",  int'(bus8.match_count), sat(m_cnt, 255));
    chk("count2",  int'(bus2.match_count), sat(m_cnt, 3));
  endtask

  task automatic drive(input bit w, input bit en, input bit mode, input bit clr);
    bus8.w    = w;
    bus8.en   = en;
    bus8.mode = mode;
    bus8.clr  = clr;
  endtask

  task automatic step(input bit w, input bit en, input bit mode, input bit clr, input bit do_chk);
    drive(w, en, mode, clr);
    m_mode = mode;
    @(posedge Clk);
    if (Resetn) model_update(w, en, mode, clr);
    #1;
    if (do_chk) check_model();
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    Resetn = 1'b0;
    model_reset();
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_z",       int'(bus8.z), 0);
    chk("rst_z_bit",   int'(bus8.z_bit), 0);
    chk("rst_run_len", int'(bus8.run_len), 0);
    chk("rst_count",   int'(bus8.match_count), 0);
    @(negedge Clk);
    Resetn = 1'b1;
  endtask

  initial begin
    bit w, en, clr, mode;

    tbl[0] = '{1'b0, LW'(1), 1'b0, 1'b0, 8'd0};
    tbl[1] = '{1'b0, LW'(2), 1'b0, 1'b0, 8'd0};
    tbl[2] = '{1'b0, LW'(3), 1'b0, 1'b0, 8'd0};
    tbl[3] = '{1'b1, LW'(1), 1'b0, 1'b1, 8'd0};
    tbl[4] = '{1'b1, LW'(2), 1'b0, 1'b1, 8'd0};
    tbl[5] = '{1'b1, LW'(3), 1'b0, 1'b1, 8'd0};
    tbl[6] = '{1'b1, LW'(4), 1'b1, 1'b1, 8'd1};

    model_reset();
    m_mode = 1'b1;
    do_reset();

    // Run of zeros broken by a run of ones.
    for (int i = 0; i < 7; i++) begin
      step(tbl[i].w, 1'b1, 1'b1, 1'b0, 1'b1);
      chk($sformatf("tbl%0d_len", i), int'(bus8.run_len),     int'(tbl[i].len));
      chk($sformatf("tbl%0d_z", i),   int'(bus8.z),           int'(tbl[i].z));
      chk($sformatf("tbl%0d_zb", i),  int'(bus8.z_bit),       int'(tbl[i].zb));
      chk($sformatf("tbl%0d_cnt", i), int'(bus8.match_count), int'(tbl[i].cnt));
    end

    // Four zeros: z rises after the fourth edge only.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      chk("zeros_z", int'(bus8.z), int'(i == 3));
    end
    chk("zeros_cnt", int'(bus8.match_count), 1);

    // Ten ones, overlap then non-overlap.
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("ovl_len", int'(bus8.run_len), 4);
    chk("ovl_cnt", int'(bus8.match_count), 1);
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      chk("novl_z", int'(bus8.z), int'(i == 3 || i == 7));
    end
    chk("novl_cnt", int'(bus8.match_count), 2);

    // Enable gap between the 2nd and 3rd equal bits.
    do_reset();
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("gap_len", int'(bus8.run_len), 2);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("gap_z3", int'(bus8.z), 0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("gap_z4", int'(bus8.z), 1);

    // Counter saturation, then clr colliding with a match edge.
    do_reset();
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("sat_cnt8", int'(bus8.match_count), 5);
    chk("sat_cnt2", int'(bus2.match_count), 3);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("clr_z",    int'(bus8.z), 1);
    chk("clr_cnt8", int'(bus8.match_count), 0);
    chk("clr_cnt2", int'(bus2.match_count), 0);

    // Asynchronous reset between edges while run_len is 3.
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    #3 Resetn = 1'b0;
    model_reset();
    #1;
    chk("arst_len", int'(bus8.run_len), 0);
    chk("arst_zb",  int'(bus8.z_bit), 0);
    chk("arst_z",   int'(bus8.z), 0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    Resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      chk("arst_fresh_z", int'(bus8.z), int'(i == 3));
    end

    // Mode switch keeps the current length and applies on the next enabled edge.
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("mode_hold_len", int'(bus8.run_len), 4);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("mode_next_len", int'(bus8.run_len), 1);

    // Randomized segments, each with a fixed mode from reset.
    for (int s = 0; s < 8; s++) begin
      do_reset();
      mode = 1'($urandom % 2);
      w = 1'b0;
      for (int i = 0; i < 80; i++) begin
        if ($urandom % 4 == 0) w = ~w;
        en  = ($urandom % 5) != 0;
        clr = ($urandom % 25) == 0;
        step(w, en, mode, clr, 1'b1);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
